// File: rtl/mem_pkg.sv
// Shared memory-stage types used by the vector store serializer and the load collector.
// A vector is LANES words; lane LANES-1 lives at the lowest memory address.
package mem_pkg;

  localparam int LANES  = 16;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [DATA_W-1:0]             word_t;
  typedef logic [LANES-1:0][DATA_W-1:0]  vec_t;
  typedef logic [ADDR_W-1:0]             addr_t;
  typedef logic [LANE_W-1:0]             lane_idx_t;

  typedef enum logic [1:0] {IDLE, STORE, DONE} store_state_t;

  // Plain-vector encodings of the store FSM for logic-typed state flops.
  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_STORE = 2'(STORE);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

endpackage

// File: rtl/mem_store_serializer_if.sv
// Request and memory-write bundle of the vector store path.
// The serializer sits on the slave side; the pipeline/memory environment is the master.
interface mem_store_serializer_if;
  import mem_pkg::*;

  logic  start;
  addr_t base_addr;
  vec_t  vec_in;
  logic  mem_ready;
  logic  mem_we;
  addr_t mem_addr;
  word_t mem_wdata;
  logic  busy;
  logic  done;

  modport master (
    output start, base_addr, vec_in, mem_ready,
    input  mem_we, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    input  start, base_addr, vec_in, mem_ready,
    output mem_we, mem_addr, mem_wdata, busy, done
  );

endinterface

// File: rtl/mem_store_serializer_lane_counter.sv
// Down-counter over vector lanes with parallel load and decrement enable.
// Shared by the store serializer and the load collector.
module lane_counter
  import mem_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      dec,
  input  lane_idx_t load_val,
  output lane_idx_t count,
  output logic      is_last
);

  lane_idx_t count_q;
  lane_idx_t count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - lane_idx_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= lane_idx_t'(LANES - 1);
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign is_last = (count_q == '0);

endmodule

// File: rtl/mem_store_serializer.sv
// Vector store path: latches one vector and emits it as LANES single-word writes,
// highest lane first at base_addr, honouring mem_ready backpressure.
module mem_store_serializer
  import mem_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  mem_store_serializer_if.slave bus
);

  logic [1:0] state_q, state_d;
  vec_t       vec_q, vec_d;
  addr_t      base_q, base_d;
  addr_t      offset_q, offset_d;
  logic       mem_we_q, mem_we_d;
  addr_t      mem_addr_q, mem_addr_d;
  word_t      mem_wdata_q, mem_wdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       cnt_load;
  logic       cnt_dec;
  lane_idx_t  cnt_count;
  logic       cnt_last;
  lane_idx_t  next_lane;
  logic       transfer;

  lane_counter u_lane_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (lane_idx_t'(LANES - 1)),
    .count    (cnt_count),
    .is_last  (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    base_d      = base_q;
    offset_d    = offset_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    next_lane   = cnt_count - lane_idx_t'(1);
    transfer    = mem_we_q && bus.mem_ready;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          vec_d       = bus.vec_in;
          base_d      = bus.base_addr;
          offset_d    = '0;
          cnt_load    = 1'b1;
          state_d     = ST_STORE;
          mem_we_d    = 1'b1;
          mem_addr_d  = bus.base_addr;
          mem_wdata_d = bus.vec_in[LANES-1];
          busy_d      = 1'b1;
        end
      end
      ST_STORE: begin
        // Outputs only move on an accepted write, so a stall holds them as-is.
        if (transfer) begin
          if (cnt_last) begin
            state_d     = ST_DONE;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            cnt_dec     = 1'b1;
            offset_d    = offset_q + addr_t'(1);
            mem_addr_d  = base_q + offset_d;
            mem_wdata_d = vec_q[next_lane];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      base_q      <= '0;
      offset_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      base_q      <= base_d;
      offset_q    <= offset_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_store_serializer.sv
// Self-checking bench for mem_store_serializer: directed and random stores against a
// write-order model, a word-addressed memory image and a load-side round-trip check.
module tb_mem_store_serializer;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   writeCount;
  word_t tbMem [0:(1 << ADDR_W) - 1];

  mem_store_serializer_if bus ();

  mem_store_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image fed by every accepted write; the round-trip check loads from it.
  always @(posedge clk) begin
    if (!rst && bus.mem_we && bus.mem_ready) begin
      tbMem[bus.mem_addr] = bus.mem_wdata;
      writeCount = writeCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_we"},    bus.mem_we, 1'b0);
    checkOutput({tag, "_busy"},  bus.busy, 1'b0);
    checkOutput({tag, "_done"},  bus.done, 1'b0);
    checkOutput({tag, "_addr"},  bus.mem_addr, addr_t'(0));
    checkOutput({tag, "_wdata"}, bus.mem_wdata, word_t'(0));
  endtask

  // One store from start to done (or to a mid-store reset), checked every cycle.
  task automatic applyStimulus(input addr_t base, input vec_t vec, input int stallPct,
                               input int stallAt, input bit intrude, input int resetAfter);
    int    k;
    int    stalls;
    int    held;
    bit    finished;
    addr_t ea;
    vec_t  loaded;
    k = 0;
    stalls = 0;
    held = 0;
    finished = 1'b0;
    writeCount = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.vec_in = vec;
    bus.mem_ready = 1'b1;
    for (int cyc = 1; cyc <= LANES * 4 + 60 && !finished; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (intrude && cyc == 5) begin
        bus.start = 1'b1;
        bus.base_addr = base + addr_t'(16'h0300);
        bus.vec_in = {LANES{16'h5555}};
      end
      if (k < LANES) begin
        ea = base + addr_t'(k);
        checkOutput("we", bus.mem_we, 1'b1);
        checkOutput("addr", bus.mem_addr, ea);
        checkOutput("wdata", bus.mem_wdata, vec[LANES-1-k]);
        checkOutput("busy", bus.busy, 1'b1);
        checkOutput("done_early", bus.done, 1'b0);
        if (resetAfter == k) begin
          checkOutput("writes_before_rst", writeCount, k);
          rst = 1'b1;
          bus.mem_ready = 1'b0;
          #1;
          checkIdle("rst_abort");
          repeat (2) begin
            @(negedge clk);
            checkIdle("rst_hold");
          end
          rst = 1'b0;
          bus.mem_ready = 1'b1;
          repeat (3) begin
            @(negedge clk);
            checkIdle("post_rst");
          end
          checkOutput("writes_after_rst", writeCount, k);
          return;
        end
        if (stallAt == k && held < 3) begin
          bus.mem_ready = 1'b0;
          held++;
        end else if ($urandom_range(99) < stallPct) begin
          bus.mem_ready = 1'b0;
        end else begin
          bus.mem_ready = 1'b1;
        end
        if (bus.mem_ready) k++;
        else stalls++;
      end else begin
        checkOutput("done", bus.done, 1'b1);
        checkOutput("done_we", bus.mem_we, 1'b0);
        checkOutput("done_busy", bus.busy, 1'b0);
        checkOutput("latency", cyc, LANES + stalls + 1);
        finished = 1'b1;
      end
    end
    if (!finished) begin
      checkOutput("timeout", 1'b0, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    @(negedge clk);
    checkIdle("after_done");
    checkOutput("write_count", writeCount, LANES);
    for (int i = 0; i < LANES; i++) begin
      ea = base + addr_t'(i);
      loaded[LANES-1-i] = tbMem[ea];
    end
    checkOutput("round_trip", loaded, vec);
  endtask

  initial begin
    vec_t  v;
    addr_t b;
    checks = 0;
    errors = 0;
    writeCount = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.vec_in = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;
    @(negedge clk);
    checkIdle("idle");

    for (int i = 0; i < LANES; i++) v[i] = word_t'(16'hA000 + i);
    $display("[TB] basic store");
    applyStimulus(16'h0100, v, 0, -1, 1'b0, -1);
    $display("[TB] backpressure at 0x0104");
    applyStimulus(16'h0100, v, 0, 4, 1'b0, -1);
    $display("[TB] address wrap");
    applyStimulus(16'hFFFE, v, 0, -1, 1'b0, -1);
    $display("[TB] start while busy");
    applyStimulus(16'h0100, v, 0, -1, 1'b1, -1);
    $display("[TB] reset mid-store");
    applyStimulus(16'h0200, v, 0, -1, 1'b0, 6);
    applyStimulus(16'h0200, v, 0, -1, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < LANES; i++) v[i] = word_t'($urandom);
      b = addr_t'($urandom);
      $display("[TB] random store %0d base %0h", r, b);
      applyStimulus(b, v, 30, -1, (r % 2) == 1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
